inst_mem_responder: RTL and testbench

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

---
 rtl/inst_mem_responder_pkg.sv | 19 +
 rtl/inst_mem_array.sv | 35 +++
 rtl/inst_mem_responder.sv | 153 +++++++++++++++
 tb/tb_inst_mem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package inst_mem_pkg_hdl;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam logic [15:0] NOP             = 16'h0000;

  // True when the fetch address has bits set above the implemented word range.
  function automatic logic addr_out_of_range(input logic [15:0] pc, input int unsigned aw);
    return (pc >> aw) != 16'h0000;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port, one registered read port.
// Contents are deliberately left without reset so a preloaded program survives.
module inst_mem_array
  import inst_mem_pkg_hdl::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rd_data_q;

  // Backdoor write port.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Synchronous read; a same-edge write is not visible here (the caller forwards).
  always_ff @(posedge clock) begin
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Wait-stated instruction fetch responder with backdoor preload.
// Optional sticky out-of-range detection when INST_MEM_RESP_ADDR_CHK_EN is defined.
module inst_mem_responder
  import inst_mem_pkg_hdl::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       PC,
  input  logic              instrmem_rd,
  output logic [15:0]       instr_dout,
  output logic              complete_instr,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data
`ifdef INST_MEM_RESP_ADDR_CHK_EN
  ,
  output logic              addr_err
`endif
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam state_e     FIRST_ST  = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              cmpl_q, cmpl_d;
  logic              busy_q, busy_d;
  logic              fwd_q, fwd_d;
  logic [15:0]       fwd_data_q, fwd_data_d;
  logic              take_s;
  logic [15:0]       rd_data_s;
  logic [15:0]       resp_word_s;

  assign take_s = instrmem_rd && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign addr_d = take_s ? ADDR_W'(PC) : addr_q;

  // The array reads the address that will be latched after this edge, so its
  // output is ready in RESP; a load hitting that address on the same edge is
  // captured here and substituted for the stale read.
  assign fwd_d      = load_en && (load_addr == addr_d);
  assign fwd_data_d = load_data;
  assign busy_d     = (state_d != ST_IDLE);

  inst_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock   (clock),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (addr_d),
    .rd_data (rd_data_s)
  );

`ifdef INST_MEM_RESP_ADDR_CHK_EN
  logic oor_q, oor_d;
  logic err_q, err_d;

  assign oor_d = take_s ? addr_out_of_range(PC, ADDR_W) : oor_q;
  assign err_d = err_q | (take_s & addr_out_of_range(PC, ADDR_W));
  assign resp_word_s = oor_q ? NOP : (fwd_q ? fwd_data_q : rd_data_s);

  // Out-of-range tracking: per-fetch flag plus sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
      err_q <= err_d;
    end
  end

  assign addr_err = err_q;
`else
  assign resp_word_s = fwd_q ? fwd_data_q : rd_data_s;
`endif

  // Next-state, wait counter and response registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    cmpl_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          state_d = FIRST_ST;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        dout_d = resp_word_s;
        cmpl_d = 1'b1;
        if (take_s) begin
          state_d = FIRST_ST;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any fetch in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      dout_q     <= NOP;
      cmpl_q     <= 1'b0;
      busy_q     <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      cmpl_q     <= cmpl_d;
      busy_q     <= busy_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign instr_dout     = dout_q;
  assign complete_instr = cmpl_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench: one responder with two wait states, one with none,
// sharing the preload bus and fetch address, checked against a memory model.
module tb_inst_mem_responder;

  localparam int W2 = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] PC;
  logic        rd2, rd0;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] dout2, dout0;
  logic        cmpl2, cmpl0, busy2, busy0;
`ifdef INST_MEM_RESP_ADDR_CHK_EN
  logic        err2, err0;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_mem [256];
  logic [15:0] last2, last0;
  logic        err_m2, err_m0;
  logic [15:0] pcq [$];

  always #5 clock = ~clock;

  inst_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W2)) dut2 (
    .clock(clock), .reset(reset), .PC(PC), .instrmem_rd(rd2),
    .instr_dout(dout2), .complete_instr(cmpl2), .busy(busy2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef INST_MEM_RESP_ADDR_CHK_EN
    , .addr_err(err2)
`endif
  );

  inst_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .PC(PC), .instrmem_rd(rd0),
    .instr_dout(dout0), .complete_instr(cmpl0), .busy(busy0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef INST_MEM_RESP_ADDR_CHK_EN
    , .addr_err(err0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_oor(input logic [15:0] pc);
`ifdef INST_MEM_RESP_ADDR_CHK_EN
    return pc[15:8] != 8'h00;
`else
    return 1'b0;
`endif
  endfunction

  // Data a fetch of pc should return: the word at pc modulo 256, or NOP if rejected.
  function automatic logic [15:0] expect_word(input logic [15:0] pc);
    if (is_oor(pc)) return 16'h0000;
    return model_mem[pc[7:0]];
  endfunction

  task automatic do_load(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    model_mem[a] = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Single fetch on the two-wait-state responder. ld_k: -2 none, -1 load on the
  // capture edge, k>=0 load on the edge after sample k. pulse_k: extra request
  // driven after sample pulse_k (during WAIT, must be ignored).
  task automatic fetch2(input logic [15:0] pc, input int ld_k, input logic [7:0] la,
                        input logic [15:0] ld, input int pulse_k, input logic [15:0] pulse_pc);
    logic [15:0] exp_w;
    PC = pc; rd2 = 1'b1;
    load_en = (ld_k == -1); load_addr = la; load_data = ld;
    // Writes up to and including the edge entering RESP are visible in the reply.
    if (ld_k >= -1 && ld_k <= W2 - 1) model_mem[la] = ld;
    exp_w = expect_word(pc);
    if (ld_k == W2) model_mem[la] = ld;
    if (is_oor(pc)) err_m2 = 1'b1;
    for (int k = 0; k <= W2 + 2; k++) begin
      @(negedge clock);
      if (k == W2 + 1) begin
        check("f2_cmpl", cmpl2, 1'b1);
        check("f2_data", dout2, exp_w);
        last2 = exp_w;
      end else begin
        check("f2_nocmpl", cmpl2, 1'b0);
        check("f2_hold", dout2, last2);
      end
      check("f2_busy", busy2, (k <= W2) ? 1'b1 : 1'b0);
`ifdef INST_MEM_RESP_ADDR_CHK_EN
      check("f2_err", err2, err_m2);
`endif
      rd2 = (k == pulse_k);
      PC = (k == pulse_k) ? pulse_pc : 16'($urandom);
      load_en = (k == ld_k);
    end
    load_en = 1'b0; rd2 = 1'b0;
  endtask

  // Back-to-back fetches on the zero-wait responder, addresses taken from pcq.
  task automatic burst0();
    logic [15:0] exp_q [$];
    int n;
    n = pcq.size();
    foreach (pcq[i]) begin
      exp_q.push_back(expect_word(pcq[i]));
      if (is_oor(pcq[i])) err_m0 = 1'b1;
    end
    PC = pcq[0]; rd0 = 1'b1;
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clock);
      if (k >= 1 && k <= n) begin
        check("b0_cmpl", cmpl0, 1'b1);
        check("b0_data", dout0, exp_q[k-1]);
        last0 = exp_q[k-1];
      end else begin
        check("b0_nocmpl", cmpl0, 1'b0);
        check("b0_hold", dout0, last0);
      end
      check("b0_busy", busy0, (k <= n - 1) ? 1'b1 : 1'b0);
      if (k + 1 < n) begin
        PC = pcq[k+1]; rd0 = 1'b1;
      end else begin
        rd0 = 1'b0; PC = 16'($urandom);
      end
    end
`ifdef INST_MEM_RESP_ADDR_CHK_EN
    check("b0_err", err0, err_m0);
`endif
  endtask

  initial begin
    reset = 1'b0; PC = 16'h0000; rd2 = 1'b0; rd0 = 1'b0;
    load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0000;
    last2 = 16'h0000; last0 = 16'h0000; err_m2 = 1'b0; err_m0 = 1'b0;

    // Reset state.
    @(negedge clock); @(negedge clock);
    check("rst_dout2", dout2, 16'h0000);
    check("rst_cmpl2", cmpl2, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    check("rst_dout0", dout0, 16'h0000);
    check("rst_busy0", busy0, 1'b0);
`ifdef INST_MEM_RESP_ADDR_CHK_EN
    check("rst_err2", err2, 1'b0);
`endif
    reset = 1'b1;

    // Preload the whole memory with random words, then the directed ones.
    for (int a = 0; a < 256; a++) do_load(a[7:0], 16'($urandom));
    do_load(8'h10, 16'h1261);

    // Scenario 1: basic fetch with two wait states.
    fetch2(16'h0010, -2, 8'h00, 16'h0000, -9, 16'h0000);

    // Scenario 2: back-to-back fetches with no wait states.
    pcq = {16'h0000, 16'h0001, 16'h0002};
    burst0();

    // Scenario 3: extra requests during WAIT are dropped.
    fetch2(16'h0020, -2, 8'h00, 16'h0000, 0, 16'h0030);
    fetch2(16'h0021, -2, 8'h00, 16'h0000, 1, 16'h0031);

    // Scenario 4: load on the edge entering RESP is forwarded.
    fetch2(16'h0010, 1, 8'h10, 16'hABCD, -9, 16'h0000);
    // Load on the edge leaving RESP is not seen by this reply, but by the next.
    fetch2(16'h0040, 2, 8'h40, 16'h5A5A, -9, 16'h0000);
    fetch2(16'h0040, -2, 8'h00, 16'h0000, -9, 16'h0000);

    // Scenario 5: reset during WAIT abandons the fetch immediately.
    PC = 16'h0010; rd2 = 1'b1;
    @(negedge clock);
    rd2 = 1'b0; reset = 1'b0;
    #1;
    check("rstw_busy", busy2, 1'b0);
    check("rstw_dout", dout2, 16'h0000);
    check("rstw_cmpl", cmpl2, 1'b0);
    last2 = 16'h0000; last0 = 16'h0000; err_m2 = 1'b0; err_m0 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("rstw_nocmpl", cmpl2, 1'b0);
    end
    fetch2(16'h0010, -2, 8'h00, 16'h0000, -9, 16'h0000);

    // Scenario 6 / wrap: upper PC bits are rejected (checked build) or ignored.
    fetch2(16'h0110, -2, 8'h00, 16'h0000, -9, 16'h0000);
    fetch2(16'h0011, -2, 8'h00, 16'h0000, -9, 16'h0000);

    // Randomized fetches with random loads and WAIT-time requests.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] rpc;
      logic [7:0]  rla;
      rpc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      rla = ($urandom_range(0, 1) == 0) ? rpc[7:0] : 8'($urandom);
      fetch2(rpc, $urandom_range(0, 4) - 2, rla, 16'($urandom),
             ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1) : -9, 16'($urandom));
    end
    for (int b = 0; b < 3; b++) begin
      pcq.delete();
      for (int j = 0; j < 2 + b * 2; j++) pcq.push_back({8'h00, 8'($urandom)});
      burst0();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
